// File: rtl/bcd_to_dec_decoder_if.sv
// Bus bundle for the BCD to 1-of-9 decimal decoder: enable, BCD weights in, decoded lines out.
// The decoder connects through the slave modport; the driver of the BCD code uses master.
interface bcd_to_dec_decoder_if;
  logic en;
  logic A1;
  logic A2;
  logic A4;
  logic A8;
  logic B1;
  logic B2;
  logic B3;
  logic B4;
  logic B5;
  logic B6;
  logic B7;
  logic B8;
  logic B9;
  logic zero;
  logic err;

  modport master (
    output en, A1, A2, A4, A8,
    input  B1, B2, B3, B4, B5, B6, B7, B8, B9, zero, err
  );

  modport slave (
    input  en, A1, A2, A4, A8,
    output B1, B2, B3, B4, B5, B6, B7, B8, B9, zero, err
  );
endinterface

// File: rtl/bcd_to_dec_decoder.sv
// BCD digit to 1-of-9 decimal line decoder with zero/illegal-code flags.
// Optionally registered (enable, async active-high reset) and optionally active-low at the port.
module bcd_to_dec_decoder #(
  parameter bit OUT_ACTIVE_LOW = 1'b0,
  parameter bit REGISTERED     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_to_dec_decoder_if.slave bus_if
);

  // Vector layout, active-high sense: [8:0] = B9..B1, [9] = zero, [10] = err.
  function automatic logic [10:0] decode_f(input logic [3:0] code);
    logic [10:0] v;
    case (code)
      4'd0:    v = 11'b010_0000_0000;
      4'd1:    v = 11'b000_0000_0001;
      4'd2:    v = 11'b000_0000_0010;
      4'd3:    v = 11'b000_0000_0100;
      4'd4:    v = 11'b000_0000_1000;
      4'd5:    v = 11'b000_0001_0000;
      4'd6:    v = 11'b000_0010_0000;
      4'd7:    v = 11'b000_0100_0000;
      4'd8:    v = 11'b000_1000_0000;
      4'd9:    v = 11'b001_0000_0000;
      default: v = 11'b100_0000_0000;
    endcase
    return v;
  endfunction

  logic [3:0]  code_s;
  logic [10:0] dec_d;
  logic [10:0] act_s;
  logic [10:0] port_s;

  assign code_s = {bus_if.A8, bus_if.A4, bus_if.A2, bus_if.A1};
  assign dec_d  = decode_f(code_s);

  generate
    if (REGISTERED) begin : g_reg
      logic [10:0] dec_q;

      // Capture the decoded digit on enabled edges; reset parks every line inactive.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dec_q <= 11'b000_0000_0000;
        end else if (bus_if.en) begin
          dec_q <= dec_d;
        end
      end

      assign act_s = dec_q;
    end else begin : g_comb
      logic unused_ok_s;
      assign unused_ok_s = ^{clk, rst, bus_if.en};
      assign act_s       = dec_d;
    end
  endgenerate

  // Inactive level (including reset) becomes 1 when the port is active-low.
  assign port_s = act_s ^ {11{OUT_ACTIVE_LOW}};

  assign bus_if.B1   = port_s[0];
  assign bus_if.B2   = port_s[1];
  assign bus_if.B3   = port_s[2];
  assign bus_if.B4   = port_s[3];
  assign bus_if.B5   = port_s[4];
  assign bus_if.B6   = port_s[5];
  assign bus_if.B7   = port_s[6];
  assign bus_if.B8   = port_s[7];
  assign bus_if.B9   = port_s[8];
  assign bus_if.zero = port_s[9];
  assign bus_if.err  = port_s[10];

endmodule

// File: tb/tb_bcd_to_dec_decoder.sv
// Self-checking bench: default, active-low and combinational decoders driven from one stimulus,
// compared every cycle against a digit-level model plus hand-computed literal expectations.
module tb_bcd_to_dec_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_s;
  logic [3:0] code_s;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mcode = -1;   // last captured digit, -1 = nothing captured since reset
  logic       run_chk = 1'b0;

  bcd_to_dec_decoder_if if_hi ();
  bcd_to_dec_decoder_if if_lo ();
  bcd_to_dec_decoder_if if_cb ();

  assign if_hi.en = en_s;
  assign if_hi.A1 = code_s[0];
  assign if_hi.A2 = code_s[1];
  assign if_hi.A4 = code_s[2];
  assign if_hi.A8 = code_s[3];
  assign if_lo.en = en_s;
  assign if_lo.A1 = code_s[0];
  assign if_lo.A2 = code_s[1];
  assign if_lo.A4 = code_s[2];
  assign if_lo.A8 = code_s[3];
  assign if_cb.en = en_s;
  assign if_cb.A1 = code_s[0];
  assign if_cb.A2 = code_s[1];
  assign if_cb.A4 = code_s[2];
  assign if_cb.A8 = code_s[3];

  bcd_to_dec_decoder u_hi (.clk(clk), .rst(rst), .bus_if(if_hi));
  bcd_to_dec_decoder #(.OUT_ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst(rst), .bus_if(if_lo));
  bcd_to_dec_decoder #(.REGISTERED(1'b0)) u_cb (.clk(clk), .rst(rst), .bus_if(if_cb));

  logic [10:0] hi_s, lo_s, cb_s;
  assign hi_s = {if_hi.err, if_hi.zero, if_hi.B9, if_hi.B8, if_hi.B7, if_hi.B6,
                 if_hi.B5, if_hi.B4, if_hi.B3, if_hi.B2, if_hi.B1};
  assign lo_s = {if_lo.err, if_lo.zero, if_lo.B9, if_lo.B8, if_lo.B7, if_lo.B6,
                 if_lo.B5, if_lo.B4, if_lo.B3, if_lo.B2, if_lo.B1};
  assign cb_s = {if_cb.err, if_cb.zero, if_cb.B9, if_cb.B8, if_cb.B7, if_cb.B6,
                 if_cb.B5, if_cb.B4, if_cb.B3, if_cb.B2, if_cb.B1};

  always #5 clk = ~clk;

  // Digit-level expectation, active-high: line n for digit n, zero flag, err flag for >9.
  function automatic logic [10:0] exp_f(input int c);
    logic [10:0] v;
    v = 11'd0;
    if (c >= 0) begin
      for (int n = 1; n <= 9; n++) v[n-1] = (c == n);
      v[9]  = (c == 0);
      v[10] = (c >= 10);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the registered decoder's captured digit.
  always @(posedge clk or posedge rst) begin
    if (rst) mcode <= -1;
    else if (en_s) mcode <= int'(code_s);
  end

  // Per-cycle compare of all three instances plus the one-hot invariant.
  always @(negedge clk) begin
    if (run_chk) begin
      check("model_hi", hi_s, exp_f(mcode));
      check("model_lo", lo_s, ~exp_f(mcode));
      check("model_cb", cb_s, exp_f(int'(code_s)));
      n_cmp++;
      if ($countones(hi_s) > 1 || $countones(~lo_s) > 1 || $countones(cb_s) > 1) begin
        n_bad++;
        $display("FAIL onehot: hi %b lo %b cb %b", hi_s, lo_s, cb_s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst    = 1'b0;
    en_s   = 1'b1;
    code_s = 4'd5;
    #1 rst = 1'b1;
    #1;
    check("rst_hi_now", hi_s, 11'h000);
    check("rst_lo_now", lo_s, 11'h7FF);
    run_chk = 1'b1;
    step();
    step();
    check("rst_hi_held", hi_s, 11'h000);
    rst = 1'b0;
    step();
    check("release_b5", hi_s, 11'h010);

    for (int c = 0; c < 16; c++) begin
      code_s = 4'(c);
      step();
      if (c == 0)  check("sweep_zero", hi_s, 11'h200);
      if (c == 1)  check("sweep_b1", hi_s, 11'h001);
      if (c == 9)  check("sweep_b9", hi_s, 11'h100);
      if (c == 10) check("sweep_err10", hi_s, 11'h400);
      if (c == 15) check("sweep_err15", hi_s, 11'h400);
    end

    code_s = 4'd3;
    step();
    check("hold_b3", hi_s, 11'h004);
    en_s   = 1'b0;
    code_s = 4'd9;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_keep_b3", hi_s, 11'h004);
    end
    en_s = 1'b1;
    step();
    check("hold_then_b9", hi_s, 11'h100);

    code_s = 4'd7;
    step();
    check("pre_rst_b7", hi_s, 11'h040);
    rst = 1'b1;
    #1;
    check("mid_rst_hi", hi_s, 11'h000);
    check("mid_rst_lo", lo_s, 11'h7FF);
    rst = 1'b0;
    #1;
    check("post_rst_no_edge", hi_s, 11'h000);
    step();
    check("post_rst_b7", hi_s, 11'h040);

    code_s = 4'd2;
    step();
    check("pol_b2", lo_s, 11'h7FD);

    en_s   = 1'b0;
    code_s = 4'd8;
    #1;
    check("comb_b8", cb_s, 11'h080);
    check("comb_ignores_en_hi_holds", hi_s, 11'h002);
    step();
    en_s = 1'b1;
    step();

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_to_dec_decoder.md
Name: bcd_to_dec_decoder

Overview:
- Registered 4-bit BCD to 1-of-9 decimal decoder for digits 1..9. Input is digit weights A1/A2/A4/A8; outputs are one-hot lines B1..B9.
- Digit 0 and the illegal codes 10..15 drive all B lines low. Two status flags report those cases.
- Sits between a BCD counter/register and per-digit indicator or select logic. Provides a clean one-cycle-registered output.

Parameters:
- OUT_ACTIVE_LOW, 0, when 1 every Bn, zero and err output is inverted at the port. The reset value follows the inactive level.
- REGISTERED, 1, when 1 outputs are registered (latency 1 clk). When 0 outputs are purely combinational and clk, rst and en are ignored.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  capture enable. When 0, registered outputs hold their value.
- A1  input  1  BCD weight-1 bit (LSB)
- A2  input  1  BCD weight-2 bit
- A4  input  1  BCD weight-4 bit
- A8  input  1  BCD weight-8 bit (MSB)
- B1..B9  output  1 each  decoded digit lines. Bn is active when code == n.
- zero  output  1  active when code == 0
- err  output  1  active when code is 10..15 (not valid BCD)

Behaviour:
- Code formation: code = 8*A8 + 4*A4 + 2*A2 + A1, an unsigned value 0..15.
- Decode function (active-high sense):
  - For code 1..9: exactly one line Bcode = 1; all other B lines, zero and err = 0.
  - For code 0: all B = 0, zero = 1, err = 0.
  - For code 10..15: all B = 0, zero = 0, err = 1.
- One-hot invariant: at most one of {B1..B9, zero, err} is active at any time. This holds for every input pattern and in reset.
- REGISTERED = 1:
  - The decode result is sampled on the rising clk edge when en = 1.
  - Outputs reflect the inputs present at the previous active edge (latency 1 cycle).
  - With en = 0, outputs hold.
- Reset:
  - rst = 1 asynchronously forces all B lines, zero and err to the inactive level, independent of clk and en.
  - Released state: after rst deasserts, outputs stay inactive until the first rising clk edge with en = 1.
  - Reset asserted mid-operation clears the outputs immediately, with no clock needed.
- REGISTERED = 0: outputs follow the inputs combinationally with no state. The reset and enable paths are absent.
- Input changes: several input bits changing together between edges produce no output glitch in registered mode. Only the value sampled at the edge matters.
- Polarity: OUT_ACTIVE_LOW = 1 inverts all eleven outputs at the port. Decode logic and latency are unchanged.
- X/Z on any A input: no requirement on the output value. err is not required to assert.

Test Plan:
- Reset: assert rst with A = 0101 and toggle clk → B1..B9, zero and err all 0 immediately and stay 0. Deassert rst, then one clk edge with en = 1 → B5 = 1, all other outputs 0.
- Full sweep: with en = 1, step the code 0..15 once per clock (A1 toggling each cycle, A2 every 2, A4 every 4, A8 every 8).
  - Code 0 → zero = 1.
  - Codes 1..9 → only Bcode = 1, one cycle after presentation.
  - Codes 10..15 → err = 1 and all B = 0.
  - Check the one-hot invariant every cycle.
- Enable hold: latch code 3 (B3 = 1), set en = 0, and apply code 9 for 3 clocks → B3 stays 1 and B9 stays 0. Set en = 1 → B9 = 1 after the next edge.
- Async reset mid-run: with B7 = 1, pulse rst between clock edges → all outputs go 0 before the next edge. After release, one edge restores B7 = 1.
- Polarity: OUT_ACTIVE_LOW = 1 with code 2 → B2 = 0 and all other outputs 1. In reset, all outputs are 1.
- Combinational mode: REGISTERED = 0, apply code 8 → B8 = 1 within the same timestep, with no clock required.
